fwrisc_fetch_seq: RTL and testbench

FWRISC_FETCH_SEQ -- requirements
Module: fwrisc_fetch_seq

---
 rtl/fwrisc_fetch_pkg.sv | 18 +
 rtl/fwrisc_fetch_seq.sv | 106 ++++++++++
 tb/tb_fwrisc_fetch_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fwrisc_fetch_pkg.sv
// Shared types and constants for the fwrisc instruction fetch sequencer.
// Holds the fetch state encoding, the pc increment and the redirect-target alignment helper.
package fwrisc_fetch_pkg;

  typedef enum logic [1:0] {
    RST = 2'd0,
    REQ = 2'd1,
    DEC = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_INCR = 32'd4;

  // Redirect targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fwrisc_fetch_seq.sv
// Fetch sequencer: one bus request per instruction, presented to decode 1 cycle after the iready handshake.
// Backpressure: the bus request holds until iready; the decoded word holds until decode_ready or a redirect.
module fwrisc_fetch_seq
  import fwrisc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic        iready,
  input  logic [31:0] idata,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] fetch_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_target
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         pend_vld;
  logic [31:0]  pend_tgt;
  logic         ivalid_q;
  logic         fetch_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  fetch_pc_q;

  logic [31:0]  branch_tgt;
  logic         redirect;
  logic [31:0]  redirect_tgt;

  // A live branch pulse outranks any redirect parked while the bus was stalled.
  assign branch_tgt   = word_align(branch_target);
  assign redirect     = branch_valid | pend_vld;
  assign redirect_tgt = branch_valid ? branch_tgt : pend_tgt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RST;
      pc            <= RESET_VECTOR;
      pend_vld      <= 1'b0;
      pend_tgt      <= 32'h0;
      ivalid_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      fetch_pc_q    <= 32'h0;
    end else begin
      case (state)
        RST: begin
          state    <= REQ;
          ivalid_q <= 1'b1;
        end

        REQ: begin
          if (iready) begin
            if (redirect) begin
              // The returned word belongs to the abandoned path; drop it and refetch.
              pc       <= redirect_tgt;
              pend_vld <= 1'b0;
            end else begin
              instr_q       <= idata;
              fetch_pc_q    <= pc;
              pc            <= pc + FETCH_INCR;
              ivalid_q      <= 1'b0;
              fetch_valid_q <= 1'b1;
              state         <= DEC;
            end
          end else if (branch_valid) begin
            // iaddr must stay put until the bus accepts, so the redirect waits here.
            pend_vld <= 1'b1;
            pend_tgt <= branch_tgt;
          end
        end

        DEC: begin
          if (branch_valid || decode_ready) begin
            if (branch_valid) begin
              pc <= branch_tgt;
            end
            fetch_valid_q <= 1'b0;
            ivalid_q      <= 1'b1;
            state         <= REQ;
          end
        end

        default: begin
          state         <= RST;
          ivalid_q      <= 1'b0;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign iaddr       = pc;
  assign ivalid      = ivalid_q;
  assign fetch_valid = fetch_valid_q;
  assign instr       = instr_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_c     = 1'b0;

endmodule

// File: tb/tb_fwrisc_fetch_seq.sv
// Directed scenarios followed by random traffic, every cycle compared against a transaction-level fetch model.
module tb_fwrisc_fetch_seq;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] FIXED = 32'h0000_0537;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] fetch_pc;
  logic        branch_valid;
  logic [31:0] branch_target;

  fwrisc_fetch_seq #(.RESET_VECTOR(RV)) dut (
    .clock         (clock),
    .reset         (reset),
    .iaddr         (iaddr),
    .ivalid        (ivalid),
    .iready        (iready),
    .idata         (idata),
    .fetch_valid   (fetch_valid),
    .decode_ready  (decode_ready),
    .instr         (instr),
    .instr_c       (instr_c),
    .fetch_pc      (fetch_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  logic use_fixed = 1'b0;

  // Model: is the core out of reset, is an instruction held for decode, and where the next fetch goes.
  logic        m_active;
  logic        m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fpc;
  logic        m_pend;
  logic [31:0] m_pend_t;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_hold = 1'b0; m_pc = RV;
    m_instr = 32'h0; m_fpc = 32'h0; m_pend = 1'b0; m_pend_t = 32'h0;
  endtask

  task automatic model_step(input logic r, input logic ir, input logic dr,
                            input logic bv, input logic [31:0] bt, input logic [31:0] word);
    logic [31:0] tgt;
    tgt = bt & 32'hFFFF_FFFC;
    if (r) model_reset();
    else if (!m_active) m_active = 1'b1;
    else if (m_hold) begin
      if (bv) begin m_pc = tgt; m_hold = 1'b0; end
      else if (dr) m_hold = 1'b0;
    end else if (ir) begin
      if (bv) begin m_pc = tgt; m_pend = 1'b0; end
      else if (m_pend) begin m_pc = m_pend_t; m_pend = 1'b0; end
      else begin m_instr = word; m_fpc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1'b1; end
    end else if (bv) begin
      m_pend = 1'b1; m_pend_t = tgt;
    end
  endtask

  // Called at a falling edge: check what the DUT shows now, then drive the next cycle's inputs.
  task automatic cyc(input logic r, input logic ir, input logic dr,
                     input logic bv, input logic [31:0] bt);
    logic exp_iv;
    exp_iv = m_active && !m_hold;
    chk("ivalid", {31'h0, ivalid}, {31'h0, exp_iv});
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, m_hold});
    chk("instr", instr, m_instr);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("instr_c", {31'h0, instr_c}, 32'h0);
    if (exp_iv) chk("iaddr", iaddr, m_pc);
    reset = r; iready = ir; decode_ready = dr; branch_valid = bv; branch_target = bt;
    idata = use_fixed ? FIXED : word_at(m_pc);
    model_step(r, ir, dr, bv, bt, idata);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; iready = 1'b0; decode_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 32'h0; idata = 32'h0;
    model_reset();
    repeat (2) @(negedge clock);

    // Outputs held at reset values while reset stays high.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);

    // Free-running fetch of a constant word: iaddr 0,4,8 with fetch_pc following.
    use_fixed = 1'b1;
    repeat (7) cyc(0, 1, 1, 0, 0);
    use_fixed = 1'b0;

    // Bus stall for 5 cycles after reset, then accept.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Decode stall for 4 cycles, then the next fetch address is fetch_pc+4.
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Redirect in DEC to an unaligned target.
    cyc(0, 0, 0, 1, 32'h0000_0103);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Get to a stalled request at 0x8, park a redirect to 0x200, then let the bus accept.
    cyc(0, 0, 0, 1, 32'h0000_0008);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_0200);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // A live branch at acceptance beats the parked one.
    cyc(0, 0, 0, 1, 32'h0000_0300);
    cyc(0, 1, 0, 1, 32'h0000_0404);
    cyc(0, 1, 0, 0, 0);

    // Reset while in DEC at fetch_pc 0x40.
    cyc(0, 0, 0, 1, 32'h0000_0040);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // pc wraps from the top word to zero.
    cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    repeat (600) begin
      logic [31:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0), bt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
